// File: rtl/uart_master_bridge.sv
// UART-to-bus master bridge: 4-byte request packets in, read data byte out.
// Contains the 8N1 uart it drives.
module uart #(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int TX_DATA_WIDTH    = 8,
    parameter int RX_DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [TX_DATA_WIDTH-1:0] data_input,
    input  logic                     data_en,
    output logic                     tx_busy,
    output logic                     u_tx,
    input  logic                     u_rx,
    output logic                     ready,
    output logic [RX_DATA_WIDTH-1:0] u_dout
);
    localparam int CW = $clog2(CLOCKS_PER_PULSE + 1);
    localparam int TLW = $clog2(TX_DATA_WIDTH + 2);
    localparam int RLW = $clog2(RX_DATA_WIDTH + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    logic [TX_DATA_WIDTH:0]   tx_sh;
    logic [CW-1:0]            tx_cnt;
    logic [TLW-1:0]           tx_left;
    rx_state_t                rx_state;
    logic                     rx_meta;
    logic                     rx_s;
    logic [RX_DATA_WIDTH-1:0] rx_sh;
    logic [CW-1:0]            rx_cnt;
    logic [RLW-1:0]           rx_left;

    // Start bit goes out on load; stop bit is the 1 shifted in behind the data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_busy <= 1'b0;
            u_tx    <= 1'b1;
            tx_sh   <= '1;
            tx_cnt  <= '0;
            tx_left <= '0;
        end else if (!tx_busy) begin
            if (data_en) begin
                tx_busy <= 1'b1;
                u_tx    <= 1'b0;
                tx_sh   <= {1'b1, data_input};
                tx_cnt  <= '0;
                tx_left <= TLW'(TX_DATA_WIDTH + 1);
            end
        end else if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_left == '0) begin
                tx_busy <= 1'b0;
            end else begin
                u_tx    <= tx_sh[0];
                tx_sh   <= {1'b1, tx_sh[TX_DATA_WIDTH:1]};
                tx_left <= tx_left - 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    // ready holds high after a good byte and drops at the next start bit.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_state <= R_IDLE;
            rx_sh    <= '0;
            rx_cnt   <= '0;
            rx_left  <= '0;
            ready    <= 1'b0;
            u_dout   <= '0;
        end else begin
            rx_meta <= u_rx;
            rx_s    <= rx_meta;
            unique case (rx_state)
                R_IDLE: begin
                    if (!rx_s) begin
                        ready    <= 1'b0;
                        rx_cnt   <= '0;
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt == HALF) begin
                        rx_cnt   <= '0;
                        rx_left  <= RLW'(RX_DATA_WIDTH);
                        rx_state <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt  <= '0;
                        rx_sh   <= {rx_s, rx_sh[RX_DATA_WIDTH-1:1]};
                        rx_left <= rx_left - 1'b1;
                        if (rx_left == RLW'(1)) rx_state <= R_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= R_IDLE;
                        if (rx_s) begin
                            u_dout <= rx_sh;
                            ready  <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end
endmodule

module uart_master_bridge #(
    parameter int DATA_WIDTH            = 8,
    parameter int ADDR_WIDTH            = 12,
    parameter int DEV_ADDR_WIDTH        = 4,
    parameter int UART_CLOCKS_PER_PULSE = 5208,
    parameter int BYTE_TIMEOUT          = 200000
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      u_rx,
    output logic                      u_tx,
    output logic                      m_req,
    output logic                      m_mode,
    output logic [DEV_ADDR_WIDTH-1:0] m_dev,
    output logic [ADDR_WIDTH-1:0]     m_addr,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    input  logic                      m_done,
    input  logic                      m_rvalid,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    output logic                      busy,
    output logic                      pkt_drop
);
    localparam int TW = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(BYTE_TIMEOUT - 1);

    typedef enum logic [1:0] {COLLECT, REQ, RESP} state_t;

    state_t                state;
    logic [1:0]            byte_cnt;
    logic [23:0]           pkt_lo;
    logic [31:0]           pkt;
    logic [TW-1:0]         timer;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  ready_q;
    logic                  arrival;
    logic                  data_en;
    logic [7:0]            data_input;
    logic                  tx_busy;
    logic                  ready;
    logic [7:0]            u_dout;

    uart #(
        .CLOCKS_PER_PULSE(UART_CLOCKS_PER_PULSE),
        .TX_DATA_WIDTH   (8),
        .RX_DATA_WIDTH   (8)
    ) u_uart (
        .clk       (clk),
        .rstn      (rstn),
        .data_input(data_input),
        .data_en   (data_en),
        .tx_busy   (tx_busy),
        .u_tx      (u_tx),
        .u_rx      (u_rx),
        .ready     (ready),
        .u_dout    (u_dout)
    );

    assign arrival = ready & ~ready_q;
    assign pkt     = {u_dout, pkt_lo};
    assign busy    = (state != COLLECT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= COLLECT;
            byte_cnt   <= '0;
            pkt_lo     <= '0;
            timer      <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b1;
            data_en    <= 1'b0;
            data_input <= '0;
            m_req      <= 1'b0;
            m_mode     <= 1'b0;
            m_dev      <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
            pkt_drop   <= 1'b0;
        end else begin
            ready_q  <= ready;
            pkt_drop <= 1'b0;
            data_en  <= 1'b0;
            unique case (state)
                COLLECT: begin
                    if (arrival) begin
                        timer <= '0;
                        unique case (byte_cnt)
                            2'd0: pkt_lo[7:0]   <= u_dout;
                            2'd1: pkt_lo[15:8]  <= u_dout;
                            2'd2: pkt_lo[23:16] <= u_dout;
                            default: ;
                        endcase
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            m_addr  <= pkt[ADDR_WIDTH-1:0];
                            m_dev   <= pkt[ADDR_WIDTH +: DEV_ADDR_WIDTH];
                            m_wdata <= pkt[16 +: DATA_WIDTH];
                            m_mode  <= pkt[24];
                            m_req   <= 1'b1;
                            state   <= REQ;
                        end
                    end else if (byte_cnt != 2'd0) begin
                        if (timer == TO_LAST) begin
                            timer    <= '0;
                            byte_cnt <= '0;
                            pkt_drop <= 1'b1;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (arrival) pkt_drop <= 1'b1;
                    if (m_mode && m_done) begin
                        m_req <= 1'b0;
                        state <= COLLECT;
                    end else if (!m_mode && m_rvalid) begin
                        rdata_q <= m_rdata;
                        m_req   <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (arrival) pkt_drop <= 1'b1;
                    if (!tx_busy && !data_en) begin
                        data_en    <= 1'b1;
                        data_input <= rdata_q[7:0];
                        state      <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_master_bridge.sv
// Scoreboard bench for uart_master_bridge: request and TX byte queues,
// checked by monitors independent of the stimulus thread.
module tb_uart_master_bridge;
    localparam int CPP = 16;
    localparam int TO  = 400;

    typedef struct {
        logic        mode;
        logic [3:0]  dev;
        logic [11:0] addr;
        logic [7:0]  wdata;
    } req_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       u_rx = 1'b1;
    logic       u_tx;
    logic       m_req;
    logic       m_mode;
    logic [3:0] m_dev;
    logic [11:0] m_addr;
    logic [7:0] m_wdata;
    logic       m_done = 1'b0;
    logic       m_rvalid = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    logic       busy;
    logic       pkt_drop;

    int checks = 0;
    int failures = 0;
    int tx_frames = 0;
    int drops = 0;
    req_t req_q[$];
    logic [7:0] tx_q[$];

    uart_master_bridge #(
        .DATA_WIDTH(8), .ADDR_WIDTH(12), .DEV_ADDR_WIDTH(4),
        .UART_CLOCKS_PER_PULSE(CPP), .BYTE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn), .u_rx(u_rx), .u_tx(u_tx),
        .m_req(m_req), .m_mode(m_mode), .m_dev(m_dev),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_done(m_done),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy),
        .pkt_drop(pkt_drop)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_rx = 1'b0;
        repeat (CPP) tick();
        for (int i = 0; i < 8; i++) begin
            u_rx = b[i];
            repeat (CPP) tick();
        end
        u_rx = 1'b1;
        repeat (CPP) tick();
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic push_req(input logic mode, input logic [3:0] dev,
                            input logic [11:0] addr, input logic [7:0] wd);
        req_t r;
        r.mode = mode;
        r.dev = dev;
        r.addr = addr;
        r.wdata = wd;
        req_q.push_back(r);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 2000 && !m_req; i++) tick();
        check("req_seen", {31'd0, m_req}, 32'd1);
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 3000 && tx_frames < n; i++) tick();
        check("tx_frames", tx_frames, n);
    endtask

    task automatic do_write_done();
        repeat (5) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        check("wr_req_drop", {31'd0, m_req}, 32'd0);
        check("wr_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_read(input logic [7:0] d);
        tx_q.push_back(d);
        m_rdata = d;
        m_rvalid = 1'b1;
        tick();
        m_rvalid = 1'b0;
        tick();
        check("rd_req_drop", {31'd0, m_req}, 32'd0);
    endtask

    // Request monitor: compares fields at m_req rise, stability at fall.
    initial begin
        logic prev = 1'b0;
        logic stable_ok = 1'b1;
        req_t cap;
        req_t e;
        forever begin
            @(negedge clk);
            if (m_req && !prev) begin
                cap.mode = m_mode;
                cap.dev = m_dev;
                cap.addr = m_addr;
                cap.wdata = m_wdata;
                stable_ok = 1'b1;
                if (req_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_req: got addr 0x%0h expected none",
                             m_addr);
                end else begin
                    e = req_q.pop_front();
                    check("m_mode", {31'd0, m_mode}, {31'd0, e.mode});
                    check("m_dev", {28'd0, m_dev}, {28'd0, e.dev});
                    check("m_addr", {20'd0, m_addr}, {20'd0, e.addr});
                    check("m_wdata", {24'd0, m_wdata}, {24'd0, e.wdata});
                end
            end else if (m_req && prev) begin
                if (m_mode !== cap.mode || m_dev !== cap.dev ||
                    m_addr !== cap.addr || m_wdata !== cap.wdata)
                    stable_ok = 1'b0;
            end else if (!m_req && prev) begin
                check("fields_stable", {31'd0, stable_ok}, 32'd1);
            end
            prev = m_req;
        end
    end

    // TX monitor: decodes 8N1 frames on u_tx.
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rstn && u_tx === 1'b0) begin
                repeat (CPP / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPP) @(negedge clk);
                    b[i] = u_tx;
                end
                repeat (CPP) @(negedge clk);
                check("tx_stop", {31'd0, u_tx}, 32'd1);
                if (tx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx: got 0x%0h expected none", b);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_byte", {24'd0, b}, {24'd0, e});
                end
                tx_frames++;
            end
        end
    end

    // Drop monitor: counts pulses and flags any wider than one cycle.
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (pkt_drop && !prev) drops++;
            if (pkt_drop && prev) begin
                checks++;
                failures++;
                $display("FAIL drop_width: got 2+ cycles expected 1");
            end
            prev = pkt_drop;
        end
    end

    initial begin
        int d0;
        repeat (3) tick();
        check("rst_m_req", {31'd0, m_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_u_tx", {31'd0, u_tx}, 32'd1);
        check("rst_addr", {20'd0, m_addr}, 32'd0);
        rstn = 1'b1;
        repeat (5) tick();

        push_req(1'b1, 4'h5, 12'h234, 8'hA5);
        send_pkt(8'h34, 8'h52, 8'hA5, 8'h01);
        wait_req();
        check("busy_in_req", {31'd0, busy}, 32'd1);
        do_write_done();
        repeat (200) tick();

        push_req(1'b0, 4'h1, 12'hF10, 8'h00);
        send_pkt(8'h10, 8'h1F, 8'h00, 8'hFE);
        wait_req();
        do_read(8'h3C);
        wait_tx(1);

        d0 = drops;
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (TO + 50) tick();
        check("timeout_drop", drops, d0 + 1);
        check("timeout_no_req", {31'd0, m_req}, 32'd0);
        push_req(1'b1, 4'h0, 12'h3AA, 8'h77);
        send_pkt(8'hAA, 8'h03, 8'h77, 8'h01);
        wait_req();
        do_write_done();

        push_req(1'b0, 4'h0, 12'h201, 8'h00);
        send_pkt(8'h01, 8'h02, 8'h00, 8'h00);
        wait_req();
        d0 = drops;
        send_byte(8'h55);
        repeat (5) tick();
        check("overrun_drop", drops, d0 + 1);
        check("overrun_addr", {20'd0, m_addr}, 32'h201);
        do_read(8'h81);
        wait_tx(2);
        push_req(1'b1, 4'h5, 12'h234, 8'hA5);
        send_pkt(8'h34, 8'h52, 8'hA5, 8'h01);
        wait_req();
        do_write_done();

        push_req(1'b0, 4'h1, 12'h320, 8'h00);
        push_req(1'b0, 4'h2, 12'h740, 8'h00);
        fork
            begin
                send_pkt(8'h20, 8'h13, 8'h00, 8'h00);
                send_pkt(8'h40, 8'h27, 8'h00, 8'h00);
            end
            begin
                wait_req();
                do_read(8'hC3);
                wait_req();
                do_read(8'h5A);
            end
        join
        wait_tx(4);

        push_req(1'b1, 4'h5, 12'h234, 8'hA5);
        send_pkt(8'h34, 8'h52, 8'hA5, 8'h01);
        wait_req();
        rstn = 1'b0;
        tick();
        check("rst_mid_req", {31'd0, m_req}, 32'd0);
        check("rst_mid_addr", {20'd0, m_addr}, 32'd0);
        check("rst_mid_dev", {28'd0, m_dev}, 32'd0);
        check("rst_mid_wdata", {24'd0, m_wdata}, 32'd0);
        check("rst_mid_mode", {31'd0, m_mode}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        tick();
        rstn = 1'b1;
        repeat (5) tick();
        push_req(1'b0, 4'h3, 12'h0AB, 8'h00);
        send_pkt(8'hAB, 8'h30, 8'h00, 8'h00);
        wait_req();
        do_read(8'hE7);
        wait_tx(5);

        repeat (50) tick();
        check("total_drops", drops, 2);
        check("req_q_empty", req_q.size(), 0);
        check("tx_q_empty", tx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
